// File: rtl/sprite_motion_pkg.sv
// rtl/sprite_motion_pkg.sv - shared types and constants for the sprite motion block
//
// Purpose: FSM state encoding, direction constants and default screen size
//          used by sprite_motion and its helpers.
// Ports:   none (package)
package sprite_motion_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

endpackage

// File: rtl/sprite_motion_edge_sync.sv
// rtl/sprite_motion_edge_sync.sv - two-flop synchronizer with rising-edge pulse
//
// Purpose: brings an asynchronous level into the clk domain and emits a
//          single-cycle pulse per rising edge. A held high level never
//          produces a second pulse. Reusable for button inputs.
// Ports:
//   clk    in  1  sampling clock
//   rst_n  in  1  asynchronous, active-low reset
//   din    in  1  asynchronous level input
//   pulse  out 1  one-cycle pulse on each synchronized rising edge
module edge_sync_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign pulse = sync2 & ~sync2_d;

endmodule

// File: rtl/sprite_motion.sv
// rtl/sprite_motion.sv - bouncing sprite position generator
//
// Purpose: advances one sprite by STEP pixels per axis on every accepted
//          update tick, clamping and reversing at the screen edges.
// Ports:
//   CLK_100MHz  in  1   system clock
//   RST_n       in  1   asynchronous, active-low reset
//   update_in   in  1   slow update strobe, synchronized internally
//   enable      in  1   1 = motion allowed
//   recenter    in  1   pulse; return to (X0,Y0), direction (1,1), IDLE
//   pos_x       out XW  sprite left-edge x
//   pos_y       out YW  sprite top-edge y
//   dir_x       out 1   1 = moving right
//   dir_y       out 1   1 = moving down
//   moved       out 1   pulse; position updated this cycle
//   bounce_x    out 1   pulse; x wall hit on this update
//   bounce_y    out 1   pulse; y wall hit on this update
module sprite_motion
  import sprite_motion_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32,
  parameter int STEP     = 2,
  parameter int X0       = 304,
  parameter int Y0       = 224,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          CLK_100MHz,
  input  logic          RST_n,
  input  logic          update_in,
  input  logic          enable,
  input  logic          recenter,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic          dir_x,
  output logic          dir_y,
  output logic          moved,
  output logic          bounce_x,
  output logic          bounce_y
);

  // One guard bit so pos + STEP cannot wrap before the wall compare.
  localparam logic [XW:0]   MAX_X_E  = (XW+1)'(SCREEN_W - SPR_W);
  localparam logic [YW:0]   MAX_Y_E  = (YW+1)'(SCREEN_H - SPR_H);
  localparam logic [XW:0]   STEP_X_E = (XW+1)'(STEP);
  localparam logic [YW:0]   STEP_Y_E = (YW+1)'(STEP);
  localparam logic [XW-1:0] MAX_X    = XW'(SCREEN_W - SPR_W);
  localparam logic [YW-1:0] MAX_Y    = YW'(SCREEN_H - SPR_H);
  localparam logic [XW-1:0] STEP_X   = XW'(STEP);
  localparam logic [YW-1:0] STEP_Y   = YW'(STEP);
  localparam logic [XW-1:0] X0_V     = XW'(X0);
  localparam logic [YW-1:0] Y0_V     = YW'(Y0);

  state_t state;
  state_t state_nxt;
  logic   tick;
  logic   accept;

  logic [XW:0]   x_ext;
  logic [XW:0]   x_plus;
  logic [YW:0]   y_ext;
  logic [YW:0]   y_plus;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic          step_dx;
  logic          step_dy;
  logic          step_bx;
  logic          step_by;

  logic [XW-1:0] pos_x_nxt;
  logic [YW-1:0] pos_y_nxt;
  logic          dir_x_nxt;
  logic          dir_y_nxt;
  logic          moved_nxt;
  logic          bounce_x_nxt;
  logic          bounce_y_nxt;

  edge_sync_pulse u_update_sync (
    .clk   (CLK_100MHz),
    .rst_n (RST_n),
    .din   (update_in),
    .pulse (tick)
  );

  // X axis step/clamp
  always_comb begin
    x_ext   = {1'b0, pos_x};
    x_plus  = x_ext + STEP_X_E;
    step_x  = pos_x;
    step_dx = dir_x;
    step_bx = 1'b0;
    if (dir_x == DIR_POS) begin
      if (x_plus >= MAX_X_E) begin
        step_x  = MAX_X;
        step_dx = DIR_NEG;
        step_bx = 1'b1;
      end else begin
        step_x  = x_plus[XW-1:0];
      end
    end else begin
      if (x_ext <= STEP_X_E) begin
        step_x  = '0;
        step_dx = DIR_POS;
        step_bx = 1'b1;
      end else begin
        step_x  = pos_x - STEP_X;
      end
    end
  end

  // Y axis step/clamp
  always_comb begin
    y_ext   = {1'b0, pos_y};
    y_plus  = y_ext + STEP_Y_E;
    step_y  = pos_y;
    step_dy = dir_y;
    step_by = 1'b0;
    if (dir_y == DIR_POS) begin
      if (y_plus >= MAX_Y_E) begin
        step_y  = MAX_Y;
        step_dy = DIR_NEG;
        step_by = 1'b1;
      end else begin
        step_y  = y_plus[YW-1:0];
      end
    end else begin
      if (y_ext <= STEP_Y_E) begin
        step_y  = '0;
        step_dy = DIR_POS;
        step_by = 1'b1;
      end else begin
        step_y  = pos_y - STEP_Y;
      end
    end
  end

  // Next-state and next-output logic. recenter wins over everything,
  // and a tick only moves the sprite while RUN with enable still high.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    dir_x_nxt    = dir_x;
    dir_y_nxt    = dir_y;
    moved_nxt    = 1'b0;
    bounce_x_nxt = 1'b0;
    bounce_y_nxt = 1'b0;

    if (recenter) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable) state_nxt = RUN;
        RUN: begin
          if (!enable) state_nxt = PAUSED;
          else if (tick) accept = 1'b1;
        end
        PAUSED:  if (enable) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end

    if (recenter) begin
      pos_x_nxt = X0_V;
      pos_y_nxt = Y0_V;
      dir_x_nxt = DIR_POS;
      dir_y_nxt = DIR_POS;
    end else if (accept) begin
      pos_x_nxt    = step_x;
      pos_y_nxt    = step_y;
      dir_x_nxt    = step_dx;
      dir_y_nxt    = step_dy;
      moved_nxt    = 1'b1;
      bounce_x_nxt = step_bx;
      bounce_y_nxt = step_by;
    end
  end

  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      state    <= IDLE;
      pos_x    <= X0_V;
      pos_y    <= Y0_V;
      dir_x    <= DIR_POS;
      dir_y    <= DIR_POS;
      moved    <= 1'b0;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      dir_x    <= dir_x_nxt;
      dir_y    <= dir_y_nxt;
      moved    <= moved_nxt;
      bounce_x <= bounce_x_nxt;
      bounce_y <= bounce_y_nxt;
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// tb/tb_sprite_motion.sv - self-checking bench for sprite_motion
module tb_sprite_motion;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a: default parameters
  logic       rst_n, upd_a, en_a, rc_a;
  logic [9:0] px_a, py_a;
  logic       dx_a, dy_a, mv_a, bx_a, by_a;

  // dut_b: small screen 64x48, sprite 8x8, step 4, start (52,36)
  logic       upd_b, en_b, rc_b;
  logic [9:0] px_b, py_b;
  logic       dx_b, dy_b, mv_b, bx_b, by_b;

  // dut_c: default screen, step 2, start (16,6), own reset
  logic       rst_c, upd_c, en_c, rc_c;
  logic [9:0] px_c, py_c;
  logic       dx_c, dy_c, mv_c, bx_c, by_c;

  sprite_motion dut_a (
    .CLK_100MHz(clk), .RST_n(rst_n), .update_in(upd_a), .enable(en_a), .recenter(rc_a),
    .pos_x(px_a), .pos_y(py_a), .dir_x(dx_a), .dir_y(dy_a),
    .moved(mv_a), .bounce_x(bx_a), .bounce_y(by_a)
  );

  sprite_motion #(
    .SCREEN_W(64), .SCREEN_H(48), .SPR_W(8), .SPR_H(8), .STEP(4), .X0(52), .Y0(36)
  ) dut_b (
    .CLK_100MHz(clk), .RST_n(rst_n), .update_in(upd_b), .enable(en_b), .recenter(rc_b),
    .pos_x(px_b), .pos_y(py_b), .dir_x(dx_b), .dir_y(dy_b),
    .moved(mv_b), .bounce_x(bx_b), .bounce_y(by_b)
  );

  sprite_motion #(.STEP(2), .X0(16), .Y0(6)) dut_c (
    .CLK_100MHz(clk), .RST_n(rst_c), .update_in(upd_c), .enable(en_c), .recenter(rc_c),
    .pos_x(px_c), .pos_y(py_c), .dir_x(dx_c), .dir_y(dy_c),
    .moved(mv_c), .bounce_x(bx_c), .bounce_y(by_c)
  );

  typedef struct {
    int x; int y; int dx; int dy; int bx; int by;
  } exp_t;

  exp_t sbq[$];
  int   mx = 52, my = 36, mdx = 1, mdy = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference behaviour of one axis for one accepted update.
  task automatic model_axis(inout int p, inout int d, output int b, input int maxv, input int st);
    b = 0;
    if (d == 1) begin
      if (p + st >= maxv) begin p = maxv; d = 0; b = 1; end
      else p = p + st;
    end else begin
      if (p <= st) begin p = 0; d = 1; b = 1; end
      else p = p - st;
    end
  endtask

  task automatic predict_b();
    exp_t e;
    int   bxv, byv;
    model_axis(mx, mdx, bxv, 56, 4);
    model_axis(my, mdy, byv, 40, 4);
    e.x = mx; e.y = my; e.dx = mdx; e.dy = mdy; e.bx = bxv; e.by = byv;
    sbq.push_back(e);
  endtask

  task automatic compare_b();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("b_unexpected_move", 32'(mv_b), 32'(0));
    end else begin
      e = sbq.pop_front();
      chk("b_pos_x", 32'(px_b), 32'(e.x));
      chk("b_pos_y", 32'(py_b), 32'(e.y));
      chk("b_dir_x", 32'(dx_b), 32'(e.dx));
      chk("b_dir_y", 32'(dy_b), 32'(e.dy));
      chk("b_bounce_x", 32'(bx_b), 32'(e.bx));
      chk("b_bounce_y", 32'(by_b), 32'(e.by));
    end
  endtask

  task automatic tick_b();
    int n;
    predict_b();
    upd_b = 1'b1;
    n = 0;
    while (!mv_b && n < 10) begin
      step_clk(1);
      n++;
    end
    chk("b_moved_seen", 32'(mv_b), 32'(1));
    if (mv_b) compare_b();
    else void'(sbq.pop_front());
    upd_b = 1'b0;
    step_clk(1);
    chk("b_moved_one_cycle", 32'(mv_b), 32'(0));
    chk("b_x_in_range", 32'(px_b <= 10'd56), 32'(1));
    step_clk(3);
  endtask

  task automatic tick_c(input int ex, input int ey);
    upd_c = 1'b1;
    step_clk(3);
    chk("c_moved", 32'(mv_c), 32'(1));
    chk("c_pos_x", 32'(px_c), 32'(ex));
    chk("c_pos_y", 32'(py_c), 32'(ey));
    upd_c = 1'b0;
    step_clk(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int guard;

    rst_n = 1'b0; rst_c = 1'b0;
    upd_a = 1'b0; en_a = 1'b0; rc_a = 1'b0;
    upd_b = 1'b0; en_b = 1'b0; rc_b = 1'b0;
    upd_c = 1'b0; en_c = 1'b0; rc_c = 1'b0;
    step_clk(2);

    // Reset state
    chk("a_rst_pos_x", 32'(px_a), 32'(304));
    chk("a_rst_pos_y", 32'(py_a), 32'(224));
    chk("a_rst_dir", 32'({dx_a, dy_a}), 32'(3));
    chk("a_rst_pulses", 32'({mv_a, bx_a, by_a}), 32'(0));
    chk("a_rst_state", 32'(dut_a.state), 32'(0));
    chk("b_rst_pos", 32'({px_b, py_b}), 32'({10'd52, 10'd36}));
    chk("c_rst_pos", 32'({px_c, py_c}), 32'({10'd16, 10'd6}));

    rst_n = 1'b1; rst_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    step_clk(2);
    chk("a_state_run", 32'(dut_a.state), 32'(1));

    // Latency: update rises between edges; result after the third edge
    upd_a = 1'b1;
    step_clk(1);
    chk("a_lat_e1_moved", 32'(mv_a), 32'(0));
    step_clk(1);
    chk("a_lat_e2_moved", 32'(mv_a), 32'(0));
    chk("a_lat_e2_pos_x", 32'(px_a), 32'(304));
    step_clk(1);
    chk("a_lat_e3_moved", 32'(mv_a), 32'(1));
    chk("a_lat_e3_pos_x", 32'(px_a), 32'(306));
    chk("a_lat_e3_pos_y", 32'(py_a), 32'(226));
    chk("a_lat_e3_bounce", 32'({bx_a, by_a}), 32'(0));
    step_clk(1);
    chk("a_lat_e4_moved", 32'(mv_a), 32'(0));
    upd_a = 1'b0;

    // Small screen: corner hit, then step back
    tick_b();
    chk("b_corner_pos", 32'({px_b, py_b}), 32'({10'd56, 10'd40}));
    chk("b_corner_dir", 32'({dx_b, dy_b}), 32'(0));
    tick_b();
    chk("b_back_pos", 32'({px_b, py_b}), 32'({10'd52, 10'd36}));

    // Walk left until x = 4, then bounce off the left wall
    guard = 0;
    while (mx != 4 && guard < 50) begin
      tick_b();
      guard++;
    end
    chk("b_reached_x4", 32'(px_b), 32'(4));
    tick_b();
    chk("b_left_wall_x", 32'(px_b), 32'(0));
    chk("b_left_wall_dir", 32'(dx_b), 32'(1));
    tick_b();
    chk("b_after_wall_x", 32'(px_b), 32'(4));

    // Held high level produces one move only
    predict_b();
    upd_b = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step_clk(1);
      if (mv_b) begin
        cnt++;
        compare_b();
      end
    end
    chk("b_hold_one_move", 32'(cnt), 32'(1));
    upd_b = 1'b0;
    step_clk(4);

    // Pause: no movement while disabled
    en_b = 1'b0;
    step_clk(1);
    chk("b_state_paused", 32'(dut_b.state), 32'(2));
    upd_b = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk(1);
      if (mv_b) cnt++;
    end
    chk("b_paused_no_move", 32'(cnt), 32'(0));
    chk("b_paused_hold_x", 32'(px_b), 32'(mx));
    chk("b_paused_hold_y", 32'(py_b), 32'(my));
    upd_b = 1'b0;
    step_clk(4);
    en_b = 1'b1;
    tick_b();
    chk("b_state_resumed", 32'(dut_b.state), 32'(1));

    // Recenter coincident with a tick while RUN at (20,10)
    tick_c(18, 8);
    tick_c(20, 10);
    upd_c = 1'b1;
    step_clk(2);
    rc_c = 1'b1;
    step_clk(1);
    rc_c = 1'b0;
    chk("c_rc_pos", 32'({px_c, py_c}), 32'({10'd16, 10'd6}));
    chk("c_rc_dir", 32'({dx_c, dy_c}), 32'(3));
    chk("c_rc_pulses", 32'({mv_c, bx_c, by_c}), 32'(0));
    chk("c_rc_state", 32'(dut_c.state), 32'(0));
    upd_c = 1'b0;
    step_clk(4);

    // Reset asserted with a synchronized edge pending
    tick_c(18, 8);
    upd_c = 1'b1;
    step_clk(2);
    #2;
    rst_c = 1'b0;
    #1;
    chk("c_async_rst_pos", 32'({px_c, py_c}), 32'({10'd16, 10'd6}));
    chk("c_async_rst_dir", 32'({dx_c, dy_c}), 32'(3));
    chk("c_async_rst_state", 32'(dut_c.state), 32'(0));
    upd_c = 1'b0;
    step_clk(2);
    rst_c = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk(1);
      if (mv_c) cnt++;
    end
    chk("c_no_move_after_rst", 32'(cnt), 32'(0));
    chk("c_hold_after_rst", 32'({px_c, py_c}), 32'({10'd16, 10'd6}));
    tick_c(18, 8);

    chk("b_scoreboard_empty", 32'(sbq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
